// File: rtl/axis_framer.sv
// ---------------------------------------------------------------------------
// axis_framer
//   Framing stage in front of the AXI-Stream FIFO. Takes an unframed beat
//   stream and asserts m_last on every len-th beat. After each frame it
//   refuses input for k idle cycles. The output register drives the FIFO
//   write port directly.
//
//   Parameters
//     Data_width  width of the data path and of the k/len config inputs
//
//   Ports
//     clk        clock, rising edge
//     rst        asynchronous reset, active-low (0 = reset)
//     in_data    unframed input data
//     in_valid   input beat valid
//     in_ready   framer can accept an input beat
//     k          idle gap in cycles after each frame (latched at frame start)
//     len        beats per frame, 0 treated as 1 (latched at frame start)
//     m_data     framed output data (registered)
//     m_valid    output beat valid (registered)
//     m_last     last beat of frame (registered, only with m_valid)
//     m_ready    downstream can accept
//     busy       frame in progress or gap active
//     frame_cnt  [16 bits] completed frames delivered downstream, wrapping.
//                Present only when FRAMER_FRAME_CNT_EN is defined.
//
//   Optional feature macro: FRAMER_FRAME_CNT_EN
// ---------------------------------------------------------------------------
module axis_framer #(
    parameter int Data_width = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [Data_width-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [Data_width-1:0] k,
    input  logic [Data_width-1:0] len,
    output logic [Data_width-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready,
`ifdef FRAMER_FRAME_CNT_EN
    output logic [15:0]           frame_cnt,
`endif
    output logic                  busy
);

    localparam logic [Data_width-1:0] ONE = Data_width'(1);

    typedef enum logic [1:0] {
        IDLE,
        BODY,
        GAP
    } state_t;

    state_t                state_q, state_n;
    logic [Data_width-1:0] cnt_q, cnt_n;
    logic [Data_width-1:0] gap_q, gap_n;
    logic [Data_width-1:0] len_q, len_n;
    logic [Data_width-1:0] k_q, k_n;
    logic [Data_width-1:0] data_n;
    logic                  valid_n;
    logic                  last_n;
    logic [Data_width-1:0] len_eff;
    logic                  is_last;
    logic                  in_fire;
    logic                  m_fire;

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gap_q   <= '0;
            len_q   <= ONE;
            k_q     <= '0;
            m_data  <= '0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            gap_q   <= gap_n;
            len_q   <= len_n;
            k_q     <= k_n;
            m_data  <= data_n;
            m_valid <= valid_n;
            m_last  <= last_n;
        end
    end

    // ------------------------------------------------------------------
    // Next-state, handshakes and output register loading
    // ------------------------------------------------------------------
    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        gap_n    = gap_q;
        len_n    = len_q;
        k_n      = k_q;
        data_n   = m_data;
        valid_n  = m_valid;
        last_n   = m_last;
        is_last  = 1'b0;

        // Ready depends only on registered state and m_ready, so there is
        // no combinational path from in_valid to any m_* output.
        in_ready = (state_q != GAP) && (!m_valid || m_ready);
        in_fire  = in_valid && in_ready;
        m_fire   = m_valid && m_ready;
        len_eff  = (len == '0) ? ONE : len;

        unique case (state_q)
            IDLE: begin
                if (in_fire) begin
                    len_n = len_eff;
                    k_n   = k;
                    cnt_n = ONE;
                    gap_n = '0;
                    if (len_eff == ONE) begin
                        is_last = 1'b1;
                        state_n = (k != '0) ? GAP : IDLE;
                    end else begin
                        state_n = BODY;
                    end
                end
            end
            BODY: begin
                if (in_fire) begin
                    // cnt holds beats already accepted in this frame.
                    if (cnt_q == len_q - ONE) begin
                        is_last = 1'b1;
                        cnt_n   = '0;
                        gap_n   = '0;
                        state_n = (k_q != '0) ? GAP : IDLE;
                    end else begin
                        cnt_n = cnt_q + ONE;
                    end
                end
            end
            GAP: begin
                // Entered only with k_q > 0; stays exactly k_q cycles.
                if (gap_q == k_q - ONE) begin
                    gap_n   = '0;
                    state_n = IDLE;
                end else begin
                    gap_n = gap_q + ONE;
                end
            end
            default: state_n = IDLE;
        endcase

        if (in_fire) begin
            data_n  = in_data;
            valid_n = 1'b1;
            last_n  = is_last;
        end else if (m_fire) begin
            valid_n = 1'b0;
            last_n  = 1'b0;
        end
    end

    assign busy = (state_q != IDLE);

`ifdef FRAMER_FRAME_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt <= '0;
        end else if (m_valid && m_ready && m_last) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_axis_framer.sv
// ---------------------------------------------------------------------------
// tb_axis_framer
//   Self-checking bench for axis_framer. A queue-based reference model tracks
//   accepted-but-undelivered beats, the position inside the current frame and
//   the remaining gap cycles; a compare process checks the DUT on every
//   falling edge. Directed sequences add literal checks on frame boundaries.
// ---------------------------------------------------------------------------
module tb_axis_framer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] k = 8'd0;
    logic [7:0] len = 8'd1;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       m_ready = 1'b0;
    logic       busy;
`ifdef FRAMER_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    always #5 clk = ~clk;

    axis_framer #(.Data_width(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .k         (k),
        .len       (len),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_last    (m_last),
        .m_ready   (m_ready),
`ifdef FRAMER_FRAME_CNT_EN
        .frame_cnt (frame_cnt),
`endif
        .busy      (busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } beat_t;

    beat_t       mq[$];          // accepted beats not yet delivered
    int          pos  = 0;       // beats accepted in current frame (0 = none)
    int          flen = 1;
    int          fk   = 0;
    int          gap  = 0;       // remaining idle cycles
    logic [15:0] fc   = 16'd0;

    function automatic bit exp_rdy();
        return (gap == 0) && ((mq.size() == 0) || (m_ready == 1'b1));
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            pos = 0;
            gap = 0;
            fc  = 16'd0;
        end else begin
            bit    rdy;
            bit    mf;
            bit    inf;
            beat_t b;
            rdy = exp_rdy();
            mf  = (mq.size() != 0) && m_ready;
            inf = in_valid && rdy;
            if (mf) begin
                if (mq[0].last) fc = fc + 16'd1;
                void'(mq.pop_front());
            end
            if (gap > 0) begin
                gap--;
            end else if (inf) begin
                if (pos == 0) begin
                    flen = (len == 8'd0) ? 1 : int'(len);
                    fk   = int'(k);
                end
                pos++;
                b.data = in_data;
                b.last = (pos == flen);
                mq.push_back(b);
                if (b.last) begin
                    pos = 0;
                    gap = fk;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Compare process
    // ------------------------------------------------------------------
    logic [8:0] log_q[$];        // delivered beats {last, data}
    int         rdy_low = 0;

    always @(negedge clk) begin
        if (rst) begin
            chk("m_valid", m_valid, mq.size() != 0);
            chk("in_ready", in_ready, exp_rdy());
            chk("busy", busy, (pos != 0) || (gap != 0));
            if (mq.size() != 0) begin
                chk("m_data", m_data, mq[0].data);
                chk("m_last", m_last, mq[0].last);
            end else begin
                chk("m_last_idle", m_last, 1'b0);
            end
`ifdef FRAMER_FRAME_CNT_EN
            chk("frame_cnt", frame_cnt, fc);
`endif
            if (!in_ready) rdy_low++;
            if (m_valid && m_ready) log_q.push_back({m_last, m_data});
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    logic [7:0] next_data = 8'd1;
    int         accepted  = 0;

    // rmode: 0 ready always high, 1 toggle, 2 random
    task automatic step(input int vprob, input int rmode);
        @(negedge clk);
        if (rst && in_valid && in_ready) begin
            next_data = next_data + 8'd1;
            accepted++;
        end
        @(posedge clk);
        #1;
        in_data  = next_data;
        in_valid = ($urandom_range(99) < vprob);
        case (rmode)
            0:       m_ready = 1'b1;
            1:       m_ready = ~m_ready;
            default: m_ready = 1'($urandom_range(1));
        endcase
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b1;
        accepted = 0;
    endtask

    task automatic drain(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) step(0, 0);
    endtask

    function automatic logic [8:0] log_at(input int idx);
        if (idx < log_q.size()) return log_q[idx];
        return 9'h1FF;
    endfunction

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        int base;
        int low0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_data", m_data, 8'd0);
        chk("rst_m_last", m_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
`ifdef FRAMER_FRAME_CNT_EN
        chk("rst_frame_cnt", frame_cnt, 16'd0);
`endif

        // 1: len=8, k=1, continuous input
        rst = 1'b1; len = 8'd8; k = 8'd1; m_ready = 1'b1;
        next_data = 8'd1; in_data = next_data; in_valid = 1'b1;
        base = log_q.size(); low0 = rdy_low;
        chk("lat_before", m_valid, 1'b0);
        step(100, 0);
        chk("lat_after", m_valid, 1'b1);
        chk("lat_data", m_data, 8'd1);
        for (int i = 0; i < 200 && accepted < 24; i++) step(100, 0);
        drain(4);
        chk("t1_count", log_q.size() - base, 24);
        chk("t1_b7", log_at(base + 6), {1'b0, 8'd7});
        chk("t1_b8", log_at(base + 7), {1'b1, 8'd8});
        chk("t1_b16", log_at(base + 15), {1'b1, 8'd16});
        chk("t1_b24", log_at(base + 23), {1'b1, 8'd24});
        chk("t1_rdy_low", rdy_low - low0, 3);

        // 2: len=0, k=0, every beat is last, no stalls
        apply_reset();
        len = 8'd0; k = 8'd0; m_ready = 1'b1;
        in_data = next_data; in_valid = 1'b1;
        base = log_q.size(); low0 = rdy_low;
        for (int i = 0; i < 20; i++) step(100, 0);
        drain(2);
        chk("t2_accepted", accepted, 20);
        chk("t2_count", log_q.size() - base, 20);
        chk("t2_rdy_low", rdy_low - low0, 0);
        for (int i = 0; i < 20; i++) chk("t2_last", log_at(base + i) >> 8, 1);

        // 3: len=4, k=3, m_ready toggling
        apply_reset();
        len = 8'd4; k = 8'd3;
        in_data = next_data; in_valid = 1'b1;
        base = log_q.size();
        for (int i = 0; i < 200; i++) step(100, 1);
        drain(6);
        chk("t3_count", log_q.size() - base, accepted);
        for (int i = 0; i < accepted; i++)
            chk("t3_last", log_at(base + i) >> 8, (i % 4) == 3);

        // 4: len changes 8 -> 3 after beat 5 of a frame
        apply_reset();
        len = 8'd8; k = 8'd0;
        in_data = next_data; in_valid = 1'b1;
        base = log_q.size();
        for (int i = 0; i < 100 && accepted < 5; i++) step(100, 0);
        len = 8'd3;
        for (int i = 0; i < 9; i++) step(100, 0);
        drain(3);
        chk("t4_b7", log_at(base + 6) >> 8, 0);
        chk("t4_b8", log_at(base + 7) >> 8, 1);
        chk("t4_b10", log_at(base + 9) >> 8, 0);
        chk("t4_b11", log_at(base + 10) >> 8, 1);
        chk("t4_b14", log_at(base + 13) >> 8, 1);

        // 5: asynchronous reset mid-frame
        apply_reset();
        len = 8'd4; k = 8'd0;
        in_data = next_data; in_valid = 1'b1;
        for (int i = 0; i < 6; i++) step(100, 0);
        @(negedge clk);
        #3;
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("t5_m_valid", m_valid, 1'b0);
        chk("t5_busy", busy, 1'b0);
        chk("t5_m_last", m_last, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
        accepted = 0;
        in_data = next_data; in_valid = 1'b1;
        base = log_q.size();
        for (int i = 0; i < 8; i++) step(100, 0);
        drain(3);
        chk("t5_b3", log_at(base + 2) >> 8, 0);
        chk("t5_b4", log_at(base + 3) >> 8, 1);
        chk("t5_b8", log_at(base + 7) >> 8, 1);

        // Boundary: 255-beat frames with a 4-cycle gap
        apply_reset();
        len = 8'd255; k = 8'd4;
        in_data = next_data; in_valid = 1'b1;
        base = log_q.size();
        for (int i = 0; i < 530; i++) step(100, 0);
        drain(6);
        chk("t255_b254", log_at(base + 253) >> 8, 0);
        chk("t255_b255", log_at(base + 254) >> 8, 1);
        chk("t255_b256", log_at(base + 255) >> 8, 0);
        chk("t255_b510", log_at(base + 509) >> 8, 1);

        // Randomised traffic with varying configuration
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            if ((i % 50) == 0) begin
                len = 8'($urandom_range(6));
                k   = 8'($urandom_range(3));
            end
            step(70, 2);
        end
        drain(10);

`ifdef FRAMER_FRAME_CNT_EN
        // Frame counter: len=2, k=0, exactly 10 beats
        apply_reset();
        len = 8'd2; k = 8'd0;
        in_data = next_data; in_valid = 1'b1;
        for (int i = 0; i < 50 && accepted < 10; i++) step(100, 0);
        in_valid = 1'b0;
        drain(4);
        chk("t6_accepted", accepted, 10);
        chk("t6_frame_cnt", frame_cnt, 16'd5);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
